video_fetch_fifo: RTL
=====================

// Module: video_fetch_fifo
// PURPOSE
//  Pixel prefetch stage that sits directly upstream of the 640x480 VGA/HDMI timing generator.
//  Reads 32-bit pixel words from memory over a strobe/ready bus and buffers them in a small FIFO.
//  Presents the FIFO head as red/green/blue/bright bytes ahead of time and pops one word per
//  fetch_next pulse. Vsync restarts the frame from base_addr; line_repeat re-reads a line (Y doubling).
// PARAMETERS
//  ADDR_WIDTH      30   width of mem_addr / base_addr (32-bit word address)
//  FIFO_LOG2       4    FIFO depth = 2**FIFO_LOG2 words (16)
//  LINE_WORDS      640  words per video line (pixels per line, 1 word/pixel)
// PORTS
//  clk_pixel    in   1           pixel clock; all logic on rising edge
//  reset_n      in   1           asynchronous, active-low reset
//  base_addr    in   ADDR_WIDTH  frame start word address; sampled on vsync rising edge
//  vga_vsync    in   1           from timing generator; high during vsync pulse
//  line_repeat  in   1           from timing generator; rising edge requests line re-fetch
//  fetch_next   in   1           pop request; 1 cycle per consumed pixel
//  mem_addr     out  ADDR_WIDTH  word address of current read
//  mem_strobe   out  1           read request; held with stable mem_addr until mem_ready
//  mem_ready    in   1           read complete; mem_data valid this cycle
//  mem_data     in   32          {bright[31:24], red[23:16], green[15:8], blue[7:0]}
//  red_byte     out  8           FIFO head red (0 when empty)
//  green_byte   out  8           FIFO head green (0 when empty)
//  blue_byte    out  8           FIFO head blue (0 when empty)
//  bright_byte  out  8           FIFO head bright (0 when empty)
//  underflow    out  1           sticky: fetch_next seen while FIFO empty
// BEHAVIOUR
//  Reset (async, reset_n=0): FIFO empty, pointers 0, mem_strobe=0, mem_addr=0, line_start=0,
//   word count=0, repeat_pending=0, underflow=0, all byte outputs 0, FSM=IDLE.
//  vsync_rise = vga_vsync & ~vsync_q (registered edge detect). On vsync_rise: FIFO flushed,
//   line_start<=base_addr, next_addr<=base_addr, word count<=0, repeat_pending<=0, underflow<=0.
//  FSM (3 states):
//   IDLE: mem_strobe=0. Go REQ when vga_vsync=0 and (fifo_count < 2**FIFO_LOG2),
//     so a slot is reserved for the one outstanding read; mem_addr<=next_addr.
//   REQ: mem_strobe=1, mem_addr stable. On mem_ready: write mem_data to FIFO; next_addr+1;
//     count+1; go IDLE. If vsync_rise occurs while in REQ without mem_ready -> DISCARD.
//     vsync_rise and mem_ready in the same cycle: data dropped, flush wins, go IDLE.
//   DISCARD: mem_strobe=1, mem_addr unchanged (bus rule: never withdraw a strobe);
//     on mem_ready, data dropped, go IDLE.
//  Line boundary: when the write makes count==LINE_WORDS, count<=0. If repeat_pending:
//   next_addr<=line_start, repeat_pending<=0. Else line_start<=next_addr+1 (start of next line).
//  line_repeat rising edge sets repeat_pending; takes effect at the next line boundary on the
//   fetch side. A second edge before that boundary has no extra effect.
//  Read side: byte outputs are combinational from FIFO head, so a word written at edge N is
//   visible after edge N when FIFO was empty. fetch_next & !empty pops at the next edge.
//   fetch_next & empty: no pop, underflow<=1, outputs stay 0.
//  Simultaneous push and pop: occupancy unchanged, both take effect. Pop of the last entry
//   together with a push: the new word becomes head. Full FIFO never receives a push,
//   guaranteed by the reservation rule above.
//  Pointers are FIFO_LOG2+1 bits; full/empty come from the MSB compare; wrap at 2**FIFO_LOG2.
//  next_addr wraps modulo 2**ADDR_WIDTH.
// TESTING
//  1 reset_n=0 mid-operation -> all outputs 0, mem_strobe=0 immediately (asynchronous reset).
//  2 base_addr=0x100, vsync pulse, mem_ready=1 always -> reads 0x100..0x10F, strobe low at
//    16 entries; red_byte = mem_data[23:16] of word 0x100.
//  3 mem_data=addr pattern, fetch_next over 640 pixels -> popped words 0x100..0x37F in order,
//    underflow=0.
//  4 mem_ready=0, fetch_next=1 -> underflow=1, bytes 0; next vsync rise clears underflow.
//  5 LINE_WORDS=4, line_repeat pulse during line 0 -> read addresses 0,1,2,3,0,1,2,3,4,5,6,7.
//  6 vsync rises with mem_strobe=1 and mem_ready=0 -> strobe and addr held until ready, data
//    dropped, FIFO empty; after vsync falls, fetch restarts at the new base_addr.

Source files
------------

// File: rtl/video_fetch_fifo_if.sv
// Memory read bus between the video prefetch stage (master) and the
// memory arbiter (slave). A read is held on mem_strobe with a stable
// mem_addr until the slave answers with mem_ready and valid mem_data.
interface video_fetch_fifo_if #(
  parameter int ADDR_WIDTH = 30
) ();

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_strobe;
  logic                  mem_ready;
  logic [31:0]           mem_data;

  modport master (
    output mem_addr,
    output mem_strobe,
    input  mem_ready,
    input  mem_data
  );

  modport slave (
    input  mem_addr,
    input  mem_strobe,
    output mem_ready,
    output mem_data
  );

endinterface

// File: rtl/video_fetch_fifo.sv
// Pixel prefetch stage feeding the 640x480 timing generator.
// Fetches 32-bit pixel words over the strobe/ready memory bus into a
// small FIFO and presents the FIFO head as bright/red/green/blue bytes.
// A vsync rising edge restarts the frame at base_addr; a line_repeat
// rising edge makes the fetch side re-read the current line once.
module video_fetch_fifo #(
  parameter int ADDR_WIDTH = 30,
  parameter int FIFO_LOG2  = 4,
  parameter int LINE_WORDS = 640
) (
  input  logic                  clk_pixel,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  vga_vsync,
  input  logic                  line_repeat,
  input  logic                  fetch_next,
  video_fetch_fifo_if.master    mem,
  output logic [7:0]            red_byte,
  output logic [7:0]            green_byte,
  output logic [7:0]            blue_byte,
  output logic [7:0]            bright_byte,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** FIFO_LOG2;
  localparam int CW    = $clog2(LINE_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } state_t;

  state_t                state;
  state_t                state_next;

  logic                  vsync_q;
  logic                  line_repeat_q;
  logic                  vsync_rise;
  logic                  repeat_rise;

  logic [31:0]           fifo_mem [DEPTH];
  logic [FIFO_LOG2:0]    wr_ptr;
  logic [FIFO_LOG2:0]    rd_ptr;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;

  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] line_start;
  logic [CW-1:0]         word_count;
  logic                  line_end;
  logic                  repeat_pending;
  logic [31:0]           head_word;

  assign vsync_rise  = vga_vsync & ~vsync_q;
  assign repeat_rise = line_repeat & ~line_repeat_q;

  // Equal low bits with differing wrap bits means full; identical pointers mean empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_LOG2] != rd_ptr[FIFO_LOG2]) &&
                      (wr_ptr[FIFO_LOG2-1:0] == rd_ptr[FIFO_LOG2-1:0]);

  // A completed read lands in the FIFO unless a frame restart flushes it away.
  assign push     = (state == REQ) && mem.mem_ready && !vsync_rise;
  assign pop      = fetch_next && !fifo_empty;
  assign line_end = push && (word_count == CW'(LINE_WORDS - 1));

  // Registered copies of vsync and line_repeat for rising-edge detection.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q       <= 1'b0;
      line_repeat_q <= 1'b0;
    end else begin
      vsync_q       <= vga_vsync;
      line_repeat_q <= line_repeat;
    end
  end

  // Fetch FSM state register.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: only issue a read when a FIFO slot is free for it; a read caught by vsync is drained, never withdrawn.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!vga_vsync && !fifo_full) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (mem.mem_ready) begin
          state_next = IDLE;
        end else if (vsync_rise) begin
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        if (mem.mem_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobe stays asserted for both live and discarded reads.
  always_comb begin
    mem.mem_strobe = 1'b0;
    if ((state == REQ) || (state == DISCARD)) begin
      mem.mem_strobe = 1'b1;
    end
  end

  // Latch the read address as a new request is launched so it stays stable until ready.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      mem.mem_addr <= '0;
    end else if ((state == IDLE) && (state_next == REQ)) begin
      mem.mem_addr <= next_addr;
    end
  end

  // Frame and line address tracking, including the line re-fetch at a line boundary.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      next_addr  <= '0;
      line_start <= '0;
      word_count <= '0;
    end else if (vsync_rise) begin
      next_addr  <= base_addr;
      line_start <= base_addr;
      word_count <= '0;
    end else if (push) begin
      if (line_end) begin
        word_count <= '0;
        if (repeat_pending) begin
          next_addr <= line_start;
        end else begin
          next_addr  <= next_addr + 1'b1;
          line_start <= next_addr + 1'b1;
        end
      end else begin
        word_count <= word_count + 1'b1;
        next_addr  <= next_addr + 1'b1;
      end
    end
  end

  // Remember a line_repeat edge until the fetch side reaches the end of the line.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      repeat_pending <= 1'b0;
    end else if (vsync_rise) begin
      repeat_pending <= 1'b0;
    end else begin
      repeat_pending <= (repeat_pending && !line_end) || repeat_rise;
    end
  end

  // FIFO pointers: flush on frame restart, otherwise push and pop independently.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (vsync_rise) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // FIFO storage; contents are only visible through the head when not empty.
  always_ff @(posedge clk_pixel) begin
    if (push) begin
      fifo_mem[wr_ptr[FIFO_LOG2-1:0]] <= mem.mem_data;
    end
  end

  // Sticky underflow flag, cleared at the start of each frame.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      underflow <= 1'b0;
    end else if (vsync_rise) begin
      underflow <= 1'b0;
    end else if (fetch_next && fifo_empty) begin
      underflow <= 1'b1;
    end
  end

  // Present the FIFO head ahead of the pop; an empty FIFO shows black.
  always_comb begin
    head_word   = fifo_mem[rd_ptr[FIFO_LOG2-1:0]];
    bright_byte = 8'h00;
    red_byte    = 8'h00;
    green_byte  = 8'h00;
    blue_byte   = 8'h00;
    if (!fifo_empty) begin
      bright_byte = head_word[31:24];
      red_byte    = head_word[23:16];
      green_byte  = head_word[15:8];
      blue_byte   = head_word[7:0];
    end
  end

endmodule
